// File: rtl/rot_cipher_stream.sv
// Streaming ROT-N cipher: transforms a byte-counted protected region of an ASCII
// stream, LANES bytes per beat, with a single registered valid/ready output stage.
module rot_cipher_stream #(
  parameter int LANES       = 4,
  parameter int KEY_DEFAULT = 13,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [4:0]         cfg_key,
  input  logic               cfg_decrypt,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
  input  logic [LANES-1:0]   s_keep,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [8*LANES-1:0] m_data,
  output logic [LANES-1:0]   m_keep,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   bytes_left
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid never waits on ready, and m_data/m_keep hold while m_valid & !m_ready.

  localparam logic [4:0] KEY_RST = 5'(KEY_DEFAULT % 26);

  typedef enum logic {IDLE, PROT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         key_q, key_d;
  logic               dec_q, dec_d;
  logic [CNT_W-1:0]   bytes_left_q, bytes_left_d;
  logic               done_q, done_d;
  logic               m_valid_q, m_valid_d;
  logic [8*LANES-1:0] m_data_q, m_data_d;
  logic [LANES-1:0]   m_keep_q, m_keep_d;

  logic               accept;
  logic [4:0]         rot_off;
  logic [CNT_W-1:0]   seen;
  logic [CNT_W-1:0]   xform_cnt;
  logic [8*LANES-1:0] beat_data;

  // Rotate one letter forward by off (0..25) within its own case.
  function automatic logic [7:0] rot_byte(input logic [7:0] b, input logic [4:0] off);
    logic [7:0] base;
    logic       alpha;
    logic [4:0] idx;
    logic [5:0] sum;
    base  = 8'h00;
    alpha = 1'b0;
    if (b >= 8'h41 && b <= 8'h5A) begin
      base  = 8'h41;
      alpha = 1'b1;
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      base  = 8'h61;
      alpha = 1'b1;
    end
    idx = 5'(b - base);
    sum = {1'b0, idx} + {1'b0, off};
    if (sum >= 6'd26) sum = sum - 6'd26;
    return alpha ? (base + {3'b000, sum[4:0]}) : b;
  endfunction

  assign s_ready    = !m_valid_q || m_ready;
  assign accept     = s_valid && s_ready;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign busy       = (state_q == PROT);
  assign done       = done_q;
  assign bytes_left = bytes_left_q;

  // Decrypt is a forward rotation by the complement of the key.
  assign rot_off = dec_q ? ((key_q == 5'd0) ? 5'd0 : (5'd26 - key_q)) : key_q;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    dec_d        = dec_q;
    bytes_left_d = bytes_left_q;
    done_d       = 1'b0;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    seen         = '0;
    xform_cnt    = '0;
    beat_data    = s_data;

    // Kept lanes are counted in lane order; only those still inside the region rotate.
    for (int i = 0; i < LANES; i++) begin
      if (s_keep[i]) begin
        if (state_q == PROT && seen < bytes_left_q) begin
          beat_data[8*i +: 8] = rot_byte(s_data[8*i +: 8], rot_off);
          xform_cnt           = xform_cnt + CNT_W'(1);
        end
        seen = seen + CNT_W'(1);
      end
    end

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = beat_data;
      m_keep_d  = s_keep;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          key_d = (cfg_key >= 5'd26) ? (cfg_key - 5'd26) : cfg_key;
          dec_d = cfg_decrypt;
          if (cfg_len != '0) begin
            state_d      = PROT;
            bytes_left_d = cfg_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PROT: begin
        if (accept) begin
          bytes_left_d = bytes_left_q - xform_cnt;
          if (xform_cnt == bytes_left_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      key_q        <= KEY_RST;
      dec_q        <= 1'b1;
      bytes_left_q <= '0;
      done_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      dec_q        <= dec_d;
      bytes_left_q <= bytes_left_d;
      done_q       <= done_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
    end
  end

endmodule

// File: tb/tb_rot_cipher_stream.sv
// Bench for rot_cipher_stream: constant vector table, hand sequences for
// backpressure / reset, then random traffic against an arithmetic reference model.
module tb_rot_cipher_stream;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [4:0]  cfg_key;
  logic        cfg_decrypt;
  logic [15:0] cfg_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        busy;
  logic        done;
  logic [15:0] bytes_left;

  rot_cipher_stream #(.LANES(4), .KEY_DEFAULT(13), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_decrypt(cfg_decrypt), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .busy(busy), .done(done), .bytes_left(bytes_left)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [35:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int mdl_key;
  bit mdl_dec;
  bit mdl_region;
  int mdl_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lane 0 carries the first character of the string.
  function automatic logic [31:0] s4(input logic [31:0] lit);
    return {lit[7:0], lit[15:8], lit[23:16], lit[31:24]};
  endfunction

  function automatic logic [7:0] ref_rot(input logic [7:0] c, input int k, input bit d);
    int ci;
    int sh;
    ci = int'(c);
    sh = d ? (26 - k) : k;
    if (ci >= 65 && ci <= 90)  return 8'(65 + ((ci - 65 + sh) % 26));
    if (ci >= 97 && ci <= 122) return 8'(97 + ((ci - 97 + sh) % 26));
    return c;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mdl_key    = 13;
    mdl_dec    = 1'b1;
    mdl_region = 1'b0;
    mdl_left   = 0;
  endtask

  // One clock cycle: drive inputs, check the output side before the edge,
  // update the model, then check status after the edge.
  task automatic step(input logic sv, input logic [31:0] sd, input logic [3:0] sk,
                      input logic mr, input logic cs, input logic [4:0] ck,
                      input logic cd, input logic [15:0] cl, output logic acc);
    logic [31:0] xd;
    logic [31:0] held;
    bit          hold_chk;
    bit          was_region;
    bit          done_exp;
    int          idx;
    s_valid = sv; s_data = sd; s_keep = sk; m_ready = mr;
    cfg_start = cs; cfg_key = ck; cfg_decrypt = cd; cfg_len = cl;
    #1;
    hold_chk = 1'b0;
    held     = m_data;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(m_data), 64'hDEAD);
      end else begin
        chk("out_beat", 64'({m_keep, m_data}), 64'(exp_q[0]));
        if (mr) void'(exp_q.pop_front());
        else hold_chk = 1'b1;
      end
    end
    chk("s_ready", 64'(s_ready), 64'(!m_valid || mr));
    acc        = sv && s_ready;
    was_region = mdl_region;
    done_exp   = 1'b0;
    if (acc) begin
      xd  = sd;
      idx = 0;
      for (int i = 0; i < 4; i++) begin
        if (sk[i]) begin
          if (was_region && idx < mdl_left) xd[8*i +: 8] = ref_rot(sd[8*i +: 8], mdl_key, mdl_dec);
          idx++;
        end
      end
      exp_q.push_back({sk, xd});
      if (was_region) begin
        mdl_left = (idx < mdl_left) ? mdl_left - idx : 0;
        if (mdl_left == 0) begin
          mdl_region = 1'b0;
          done_exp   = 1'b1;
        end
      end
    end
    if (cs && !was_region) begin
      mdl_key = int'(ck) % 26;
      mdl_dec = cd;
      if (cl != 16'd0) begin
        mdl_region = 1'b1;
        mdl_left   = int'(cl);
      end else begin
        done_exp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (hold_chk) chk("hold_stable", 64'(m_data), 64'(held));
    chk("busy", 64'(busy), 64'(mdl_region));
    chk("bytes_left", 64'(bytes_left), 64'(mdl_left));
    chk("done", 64'(done), 64'(done_exp));
  endtask

  task automatic idle_cycle(input logic mr);
    logic a;
    step(1'b0, 32'h0, 4'h0, mr, 1'b0, 5'd0, 1'b0, 16'd0, a);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start;
    logic [4:0]  key;
    logic        dec;
    logic [15:0] len;
    logic [31:0] din;
    logic [3:0]  keep;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic        acc;
    logic        pend;
    logic        sv, mr, cs, cd;
    logic [31:0] sd;
    logic [3:0]  sk;
    logic [4:0]  ck;
    logic [15:0] cl;
    logic [31:0] seq[3];
    int          bi;

    vecs[0] = '{1'b0, 5'd0,  1'b0, 16'd0, s4("Uryy"), 4'hF, s4("Uryy")};
    vecs[1] = '{1'b1, 5'd13, 1'b1, 16'd5, s4("Uryy"), 4'hF, s4("Hell")};
    vecs[2] = '{1'b0, 5'd0,  1'b0, 16'd0, s4("b!xx"), 4'hF, s4("o!xx")};
    vecs[3] = '{1'b1, 5'd3,  1'b0, 16'd6, s4("xyzA"), 4'hF, s4("abcD")};
    vecs[4] = '{1'b0, 5'd0,  1'b0, 16'd0, s4("BC.."), 4'hF, s4("EF..")};
    vecs[5] = '{1'b1, 5'd29, 1'b0, 16'd6, s4("xyzA"), 4'hF, s4("abcD")};
    vecs[6] = '{1'b0, 5'd0,  1'b0, 16'd0, s4("BC.."), 4'hF, s4("EF..")};
    vecs[7] = '{1'b1, 5'd1,  1'b0, 16'd2, s4("abcd"), 4'h7, s4("bccd")};
    vecs[8] = '{1'b1, 5'd0,  1'b1, 16'd4, s4("Zz9a"), 4'hF, s4("Zz9a")};
    vecs[9] = '{1'b1, 5'd5,  1'b0, 16'd0, s4("abcd"), 4'hF, s4("abcd")};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_keep = '0; m_ready = 1'b1;
    cfg_start = 1'b0; cfg_key = '0; cfg_decrypt = 1'b0; cfg_len = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_keep", 64'(m_keep), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bytes_left", 64'(bytes_left), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table ----------------
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].start)
        step(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, vecs[v].key, vecs[v].dec, vecs[v].len, acc);
      step(1'b1, vecs[v].din, vecs[v].keep, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0, acc);
      chk($sformatf("vec%0d_acc", v), 64'(acc), 64'd1);
      chk($sformatf("vec%0d_data", v), 64'(m_data), 64'(vecs[v].dout));
      chk($sformatf("vec%0d_keep", v), 64'(m_keep), 64'(vecs[v].keep));
    end
    idle_cycle(1'b1);

    // ---------------- backpressure mid-region ----------------
    step(1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 5'd13, 1'b1, 16'd12, acc);
    seq[0] = s4("Uryy"); seq[1] = s4("Jbey"); seq[2] = s4("qn!!");
    bi = 0;
    for (int c = 0; c < 12 && bi < 3; c++) begin
      mr = (c >= 1 && c <= 4) ? 1'b0 : 1'b1;
      step(1'b1, seq[bi], 4'hF, mr, 1'b0, 5'd0, 1'b0, 16'd0, acc);
      if (acc) bi++;
    end
    chk("bp_all_accepted", 64'(bi), 64'd3);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- async reset while busy with a held beat ----------------
    step(1'b1, s4("abcd"), 4'hF, 1'b0, 1'b1, 5'd7, 1'b0, 16'd10, acc);
    idle_cycle(1'b0);
    chk("pre_rst_left", 64'(bytes_left), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_m_data", 64'(m_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_bytes_left", 64'(bytes_left), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, s4("Uryy"), 4'hF, 1'b1, 1'b0, 5'd0, 1'b0, 16'd0, acc);
    chk("post_rst_bypass", 64'(m_data), 64'(s4("Uryy")));
    idle_cycle(1'b1);

    // ---------------- random traffic ----------------
    pend = 1'b0;
    sv = 1'b0; sd = '0; sk = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend) begin
        sv = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) sd[8*i +: 8] = 8'($urandom_range(32, 126));
        sk = 4'((5'd1 << $urandom_range(1, 4)) - 5'd1);
      end
      mr = ($urandom_range(0, 3) != 0);
      cs = ($urandom_range(0, 9) == 0);
      ck = 5'($urandom_range(0, 31));
      cd = 1'($urandom_range(0, 1));
      cl = 16'($urandom_range(0, 12));
      step(sv, sd, sk, mr, cs, ck, cd, cl, acc);
      pend = sv && !acc;
    end
    for (int n = 0; n < 3; n++) idle_cycle(1'b1);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
